// File: rtl/imem_responder.sv
// Fetch-side memory responder: one outstanding 64-bit aligned read per request, multi-cycle handshake.
// Optional build macro IMEM_RESPONDER_RAND_DELAY_EN adds 0..3 LFSR-driven extra wait cycles per request.
module imem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter logic [63:0] SIZE    = 64'h0000_0000_0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  // valid/ready on both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds valid and payload stable while valid && !ready.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  // Physical memory read port; pmem_ren marks the single read made for a request.
  output logic        pmem_ren,
  output logic [63:0] pmem_raddr,
  input  logic [63:0] pmem_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        in_range_q, in_range_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic [63:0] aligned_addr;
  logic        req_in_range;
  logic [4:0]  load_cnt;

  assign aligned_addr = req_addr & ~64'h7;
  // Subtraction form stays correct even if BASE+SIZE wraps past 2^64.
  assign req_in_range = (aligned_addr >= BASE) && ((aligned_addr - BASE) < SIZE);

`ifdef IMEM_RESPONDER_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign load_cnt = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign load_cnt = 5'(LATENCY);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      in_range_q  <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      in_range_q  <= in_range_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    in_range_d  = in_range_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = aligned_addr;
          in_range_d = req_in_range;
          cnt_d      = load_cnt;
          state_d    = (load_cnt != 5'd0) ? S_WAIT : S_FILL;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) state_d = S_FILL;
      end
      S_FILL: begin
        resp_data_d = in_range_q ? pmem_rdata : 64'h0;
        resp_err_d  = !in_range_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign pmem_ren   = (state_q == S_FILL) && in_range_q;
  assign pmem_raddr = addr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed steps then random fetches against a memory/range reference model.
module tb_imem_responder;

  localparam int unsigned LAT  = 2;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE = 64'h0000_0000_0800_0000;
  localparam int LO_A = LAT + 1;
  localparam int LO_B = 1;
`ifdef IMEM_RESPONDER_RAND_DELAY_EN
  localparam int HI_A = LAT + 4;
  localparam int HI_B = 4;
`else
  localparam int HI_A = LAT + 1;
  localparam int HI_B = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a, pmem_ren_a;
  logic [63:0] req_addr_a, resp_data_a, pmem_raddr_a, pmem_rdata_a;
  logic [1:0]  state_dbg_a;
  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b, pmem_ren_b;
  logic [63:0] req_addr_b, resp_data_b, pmem_raddr_b, pmem_rdata_b;
  logic [1:0]  state_dbg_b;

  // Memory contents: one fixed preload, everything else a hash of the aligned address.
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00100093_00000513;
    return {a[31:0] ^ 32'h9E37_79B9, a[34:3] * 32'h0100_0193};
  endfunction

  assign pmem_rdata_a = mem_fn(pmem_raddr_a);
  assign pmem_rdata_b = mem_fn(pmem_raddr_b);

  imem_responder #(.LATENCY(LAT), .BASE(BASE), .SIZE(SIZE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a), .resp_data(resp_data_a), .resp_err(resp_err_a),
    .pmem_ren(pmem_ren_a), .pmem_raddr(pmem_raddr_a), .pmem_rdata(pmem_rdata_a), .state_dbg(state_dbg_a)
  );

  imem_responder #(.LATENCY(0), .BASE(BASE), .SIZE(SIZE)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_data(resp_data_b), .resp_err(resp_err_b),
    .pmem_ren(pmem_ren_b), .pmem_raddr(pmem_raddr_b), .pmem_rdata(pmem_rdata_b), .state_dbg(state_dbg_b)
  );

  // ---------------- reference model + scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  logic [64:0] exp_q[$];

  // {err, data}: legal window is [BASE, BASE+SIZE) on the aligned address.
  function automatic logic [64:0] model(input logic [63:0] addr);
    logic [63:0] a;
    a = {addr[63:3], 3'b000};
    if (a >= BASE && a < BASE + SIZE) return {1'b0, mem_fn(a)};
    return {1'b1, 64'h0};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int cyc = 0;
  int calls_a = 0;
  int calls_b = 0;
  logic rv_prev_b = 1'b0;
  int acc_b[$];
  int rv_b[$];
  logic [64:0] got_b[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pmem_ren_a) calls_a <= calls_a + 1;
    if (pmem_ren_b) calls_b <= calls_b + 1;
    if (req_valid_b && req_ready_b) acc_b.push_back(cyc + 1);
    if (resp_valid_b && !rv_prev_b) rv_b.push_back(cyc);
    if (resp_valid_b && resp_ready_b) got_b.push_back({resp_err_b, resp_data_b});
    rv_prev_b <= resp_valid_b;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [63:0] addr, input int stall);
    int c0, lat;
    logic busy_ok, stable_ok;
    logic [64:0] hold, exp;
    c0 = calls_a;
    exp_q.push_back(model(addr));
    check("idle_ready", 65'(req_ready_a), 65'd1);
    req_valid_a  = 1'b1;
    req_addr_a   = addr;
    resp_ready_a = (stall == 0);
    step();
    req_valid_a = 1'b0;
    req_addr_a  = {$urandom, $urandom};
    lat = 0;
    busy_ok = 1'b1;
    while (!resp_valid_a && lat < 40) begin
      if (req_ready_a) busy_ok = 1'b0;
      step();
      lat++;
    end
    check("lat_window", 65'(lat >= LO_A && lat <= HI_A), 65'd1);
    hold = {resp_err_a, resp_data_a};
    stable_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      step();
      if (!resp_valid_a || {resp_err_a, resp_data_a} !== hold || req_ready_a) stable_ok = 1'b0;
    end
    resp_ready_a = 1'b1;
    step();
    exp = exp_q.pop_front();
    check("resp", hold, exp);
    check("busy_stable", 65'(busy_ok && stable_ok), 65'd1);
    check("post_handshake", 65'({resp_valid_a, req_ready_a}), 65'b01);
    check("pmem_calls", 65'(calls_a - c0), exp[64] ? 65'd0 : 65'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c0;
    logic seen;
    logic [63:0] a;
    logic [63:0] oor[4];
    req_valid_a = 1'b0; req_addr_a = '0; resp_ready_a = 1'b1;
    req_valid_b = 1'b0; req_addr_b = '0; resp_ready_b = 1'b1;
    #2 reset = 1'b0;
    step(); step();
    check("rst_ready", 65'(req_ready_a), 65'd1);
    check("rst_valid", 65'(resp_valid_a), 65'd0);
    check("rst_resp", {resp_err_a, resp_data_a}, 65'd0);
    reset = 1'b1;
    step();

    // single fetch, back-pressure, range boundaries
    fetch(64'h0000_0000_8000_0004, 0);
    fetch(64'h0000_0000_8000_0004, 5);
    fetch(64'h0000_0000_7FFF_FFF8, 0);
    fetch(64'h0000_0000_8800_0000, 2);
    fetch(64'h0000_0000_87FF_FFFF, 0);
    fetch(64'h0000_0000_8000_0000, 1);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 0);

    // LATENCY=0 back-to-back with req_valid held
    req_valid_b = 1'b1;
    req_addr_b  = 64'h0000_0000_8000_0000;
    n = 0;
    while (acc_b.size() < 1 && n < 20) begin step(); n++; end
    req_addr_b = 64'h0000_0000_8000_0008;
    while (acc_b.size() < 2 && n < 40) begin step(); n++; end
    req_valid_b = 1'b0;
    repeat (6) step();
    check("b2b_accepts", 65'(acc_b.size()), 65'd2);
    check("b2b_responses", 65'(got_b.size()), 65'd2);
    if (acc_b.size() >= 2 && rv_b.size() >= 2 && got_b.size() >= 2) begin
      check("b2b_lat0", 65'(rv_b[0] - acc_b[0] >= LO_B && rv_b[0] - acc_b[0] <= HI_B), 65'd1);
      check("b2b_lat1", 65'(rv_b[1] - acc_b[1] >= LO_B && rv_b[1] - acc_b[1] <= HI_B), 65'd1);
      check("b2b_period", 65'(acc_b[1] - acc_b[0]), 65'(rv_b[0] - acc_b[0] + 2));
      check("b2b_data0", got_b[0], model(64'h0000_0000_8000_0000));
      check("b2b_data1", got_b[1], model(64'h0000_0000_8000_0008));
    end
    check("b2b_calls", 65'(calls_b), 65'd2);

    // reset while waiting
    c0 = calls_a;
    req_valid_a = 1'b1;
    req_addr_a  = 64'h0000_0000_8000_0020;
    step();
    req_valid_a = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rst_wait_state", 65'({resp_valid_a, req_ready_a}), 65'b01);
    step();
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin step(); if (resp_valid_a) seen = 1'b1; end
    check("rst_wait_noresp", 65'(seen), 65'd0);
    check("rst_wait_calls", 65'(calls_a - c0), 65'd0);

    // reset while a response is stalled: resp_valid must fall without a clock edge
    req_valid_a  = 1'b1;
    req_addr_a   = 64'h0000_0000_8000_0030;
    resp_ready_a = 1'b0;
    step();
    req_valid_a = 1'b0;
    n = 0;
    while (!resp_valid_a && n < 40) begin step(); n++; end
    check("rst_resp_pre", 65'(resp_valid_a), 65'd1);
    reset = 1'b0;
    #1;
    check("rst_resp_async", 65'(resp_valid_a), 65'd0);
    step();
    reset = 1'b1;
    resp_ready_a = 1'b1;
    seen = 1'b0;
    repeat (6) begin step(); if (resp_valid_a) seen = 1'b1; end
    check("rst_resp_noresp", 65'(seen), 65'd0);
    fetch(64'h0000_0000_8000_0010, 0);

    // random fetches
    oor[0] = 64'h0000_0000_7FFF_FFFF;
    oor[1] = 64'h0000_0000_8800_0000;
    oor[2] = 64'h0000_0000_0000_0000;
    oor[3] = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) < 8) a = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
      else                          a = oor[$urandom_range(0, 3)];
      fetch(a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
